// File: rtl/fifo_pkg.sv
// Shared constants and types for the 8-bit sync FIFO and its stream reader.
// Common to the FIFO core and all read/write side controllers.
package fifo_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int STATS_W    = 16;

  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/fifo_stream_rd_buf.sv
// Circular register buffer between the FIFO read port and the stream output.
// Push captures a returning FIFO byte; pop retires the head entry.
module fifo_stream_rd_buf #(
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = 8,
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OW = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [OW-1:0]     o_occ,
  output logic [DATA_W-1:0] o_head
);

  import fifo_pkg::*;

  if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_bad_depth
    $error("fifo_stream_rd_buf: BUF_DEPTH must be 2..8");
  end

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [OW-1:0]     r_occ;

  // Explicit wrap keeps non-power-of-2 depths inside the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && r_occ == OW'(BUF_DEPTH)));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(i_pop && r_occ == '0));

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side controller: issues reads, absorbs read latency, emits a stream.
// Build option FIFO_STREAM_READER_STATS_EN adds cnt_clr / rd_count pop counter.
module fifo_stream_reader #(
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = fifo_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic                       fifo_re,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
`ifdef FIFO_STREAM_READER_STATS_EN
  input  logic                       cnt_clr,
  output logic [fifo_pkg::STATS_W-1:0] rd_count,
`endif
  output logic                       busy
);

  import fifo_pkg::*;

  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = OW + 1;

  logic          r_inflight;
  logic [OW-1:0] w_occ;
  logic [CW-1:0] w_credit;
  logic          w_pop;

  assign w_pop   = m_valid && m_ready;
  assign m_valid = (w_occ != '0);
  assign busy    = m_valid || r_inflight;

  // Slots committed after this edge; a same-cycle pop frees one.
  assign w_credit = CW'(w_occ) + CW'(r_inflight) - CW'(w_pop);

  assign fifo_re = en && !fifo_empty && rst_n
                && (w_credit < CW'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= 1'b0;
    else        r_inflight <= fifo_re;
  end

  fifo_stream_rd_buf #(
    .BUF_DEPTH (BUF_DEPTH),
    .DATA_W    (DATA_W)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_inflight),
    .i_data (fifo_data),
    .i_pop  (w_pop),
    .o_occ  (w_occ),
    .o_head (m_data)
  );

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [STATS_W-1:0] r_rd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
    end else if (cnt_clr) begin
      r_rd_count <= '0;
    end else if (w_pop && r_rd_count != '1) begin
      r_rd_count <= r_rd_count + STATS_W'(1);
    end
  end

  assign rd_count = r_rd_count;
`endif

  a_credit: assert property (
    @(posedge clk) disable iff (!rst_n)
    (CW'(w_occ) + CW'(r_inflight)) <= CW'(BUF_DEPTH));

  a_no_read_empty: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(fifo_re && fifo_empty));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO.
// Stats checks are compiled in with FIFO_STREAM_READER_STATS_EN.
module tb_fifo_stream_reader;

  import fifo_pkg::*;

  logic  clk     = 1'b0;
  logic  rst_n   = 1'b0;
  logic  en      = 1'b0;
  logic  m_ready = 1'b0;
  logic  fifo_empty;
  byte_t fifo_data = '0;
  logic  fifo_re;
  logic  m_valid;
  byte_t m_data;
  logic  busy;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] rd_count;
`endif

  int errs = 0;
  int nchk = 0;

  byte_t fmem [64];
  int    wp   = 0;
  int    rp   = 0;
  int    n_re = 0;

  always #5 clk = ~clk;

  fifo_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
`ifdef FIFO_STREAM_READER_STATS_EN
    .cnt_clr    (cnt_clr),
    .rd_count   (rd_count),
`endif
    .busy       (busy)
  );

  // FIFO model: registered read data, valid the cycle after fifo_re.
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_data <= fmem[rp % 64];
      rp        <= rp + 1;
    end
    n_re <= n_re + (fifo_re ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put(input byte_t b);
    fmem[wp % 64] = b;
    wp++;
  endtask

  // Pops n bytes (m_ready must be 1) and checks they run base, base+1, ...
  task automatic drain(input string tag, input int n, input int base,
                       input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (m_valid && m_ready) begin
        check(tag, 32'(m_data), 32'(base + got));
        got++;
      end
      step();
    end
    check({tag, "_cnt"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int c;

    // Reset: a waiting byte must not be read while rst_n is low.
    en      = 1'b1;
    m_ready = 1'b1;
    put(8'hA5);
    step();
    step();
    check("rst_re",    fifo_re, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data",  m_data,  0);
    check("rst_busy",  busy,    0);
`ifdef FIFO_STREAM_READER_STATS_EN
    check("rst_count", rd_count, 0);
`endif

    // Basic transfer: read in first cycle out of reset, data 2 cycles later.
    rst_n = 1'b1;
    #1 check("b_re_first", fifo_re, 1);
    step();
    check("b_re_pulse", fifo_re, 0);
    check("b_lat1",     m_valid, 0);
    check("b_busy",     busy,    1);
    step();
    check("b_valid", m_valid, 1);
    check("b_data",  m_data,  8'hA5);
    step();
    check("b_idle",  m_valid,    0);
    check("b_nbusy", busy,       0);
    check("b_empty", fifo_empty, 1);
    check("b_nre",   n_re,       1);

    // Streaming 16 bytes with no bubbles after the first.
    en = 1'b0;
    for (int i = 0; i < 16; i++) put(byte_t'(i));
    #1 check("s_en_gate", fifo_re, 0);
    step();
    en = 1'b1;
    #1 check("s_re", fifo_re, 1);
    step();
    check("s_lat1", m_valid, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      check("s_valid", m_valid, 1);
      check("s_data",  m_data,  i);
      step();
    end
    check("s_done", m_valid, 0);
    check("s_busy", busy,    0);

    // Backpressure: only BUF_DEPTH reads issue, head held stable.
    m_ready = 1'b0;
    en      = 1'b0;
    for (int i = 0; i < 16; i++) put(byte_t'(i));
    n0 = n_re;
    en = 1'b1;
    repeat (6) step();
    check("bp_reads", n_re - n0, 2);
    check("bp_left",  wp - rp,   14);
    check("bp_valid", m_valid,   1);
    check("bp_data",  m_data,    8'h00);
    check("bp_re",    fifo_re,   0);
    step();
    check("bp_hold", m_data, 8'h00);
    m_ready = 1'b1;
    drain("bp", 16, 0, 60);
    check("bp_busy", busy, 0);

    // en dropped right after the issuing cycle.
    en = 1'b0;
    for (int i = 0; i < 4; i++) put(byte_t'(8'h10 + i));
    n0 = n_re;
    en = 1'b1;
    #1 check("en_re", fifo_re, 1);
    step();
    en = 1'b0;
    #1 check("en_off", fifo_re, 0);
    drain("en", 1, 8'h10, 6);
    repeat (3) step();
    check("en_reads", n_re - n0, 1);
    check("en_idle",  m_valid,   0);
    check("en_left",  wp - rp,   3);
    en = 1'b1;
    drain("en_back", 3, 8'h11, 20);

    // Asynchronous reset with two bytes buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(byte_t'(8'h20 + i));
    repeat (4) step();
    check("r_valid_pre", m_valid, 1);
    check("r_busy_pre",  busy,    1);
    check("r_left_pre",  wp - rp, 2);
    #2 rst_n = 1'b0;
    #1;
    check("r_valid", m_valid, 0);
    check("r_re",    fifo_re, 0);
    check("r_busy",  busy,    0);
    check("r_data",  m_data,  0);
    wp = rp;
    put(8'h3C);
    m_ready = 1'b1;
    step();
    rst_n = 1'b1;
    drain("r_new", 1, 8'h3C, 10);
    repeat (3) step();
    check("r_after", m_valid,    0);
    check("r_rbusy", busy,       0);
    check("r_empty", fifo_empty, 1);

`ifdef FIFO_STREAM_READER_STATS_EN
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("st_clr", rd_count, 0);
    for (int i = 0; i < 20; i++) put(byte_t'(8'h40 + i));
    drain("st", 20, 8'h40, 60);
    check("st_20", rd_count, 20);

    put(8'h55);
    c = 0;
    while (!m_valid && c < 10) begin
      step();
      c++;
    end
    check("st_wait", m_valid, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("st_clr_pop", rd_count, 0);
    check("st_popped",  m_valid,  0);

    dut.r_rd_count = 16'hFFFE;
    for (int i = 0; i < 3; i++) put(byte_t'(8'h60 + i));
    drain("st_sat", 3, 8'h60, 20);
    check("st_sat_val", rd_count, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
